// File: rtl/contador_salida.sv
// contador_salida: output-side consumer behind the D0/D1 destination FIFOs.
// Pops both FIFOs, counts words per class and reports counts while idle.
module contador_salida #(
    parameter int BW = 6,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic          idle,
    input  logic          D0_empty,
    input  logic          D0_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic          D1_empty,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D1_data_out,
    input  logic          req,
    input  logic [1:0]    idx,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic          valid,
    output logic [CW-1:0] contador,
    output logic [3:0]    overflow
);

    typedef enum logic [1:0] {
        COUNT     = 2'd0,
        WAIT_IDLE = 2'd1,
        REPORT    = 2'd2
    } state_t;

    localparam logic [CW:0] SAT = {1'b0, {CW{1'b1}}};

    state_t state_q;
    state_t state_d;
    logic [1:0] idx_q;
    logic [1:0] idx_d;
    logic valid_q;
    logic valid_d;
    logic [CW-1:0] contador_q;
    logic [CW-1:0] contador_d;

    logic rd0_q;
    logic rd0_d;
    logic rd1_q;
    logic rd1_d;

    logic [3:0][CW-1:0] cnt_q;
    logic [3:0][CW-1:0] cnt_d;
    logic [3:0] ovf_q;
    logic [3:0] ovf_d;

    logic [3:0][1:0] inc;
    logic [3:0][CW:0] sum;

    logic [1:0] cls0;
    logic [1:0] cls1;
    logic drained;
    logic data_unused;

    // Only the class field of each word matters here.
    assign cls0 = D0_data_out[BW-1:BW-2];
    assign cls1 = D1_data_out[BW-1:BW-2];
    assign data_unused = ^{D0_data_out[BW-3:0], D1_data_out[BW-3:0]};

    // Pops run only while counting; a FIFO in error is left alone.
    assign D0_rd = reset_L & ~D0_empty & ~D0_error_output
                 & (state_q == COUNT);
    assign D1_rd = reset_L & ~D1_empty & ~D1_error_output
                 & (state_q == COUNT);

    assign rd0_d = D0_rd;
    assign rd1_d = D1_rd;

    // No read data can still be in flight when both capture flags are low.
    assign drained = idle & ~rd0_q & ~rd1_q;

    assign valid    = valid_q;
    assign contador = contador_q;
    assign overflow = ovf_q;

    // Per-class increment of 0..2 with saturation and sticky overflow.
    always_comb begin
        inc   = '0;
        sum   = '0;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int c = 0; c < 4; c++) begin
            inc[c] = {1'b0, rd0_q && (cls0 == 2'(c))}
                   + {1'b0, rd1_q && (cls1 == 2'(c))};
            sum[c] = {1'b0, cnt_q[c]} + {{(CW-1){1'b0}}, inc[c]};
            if (sum[c] > SAT) begin
                cnt_d[c] = SAT[CW-1:0];
                ovf_d[c] = 1'b1;
            end else begin
                cnt_d[c] = sum[c][CW-1:0];
            end
        end
        if (init) begin
            cnt_d = '0;
            ovf_d = '0;
        end
    end

    // Report sequencing: stop pops, wait for a drained pipe, then report.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = 1'b0;
        contador_d = contador_q;
        unique case (state_q)
            COUNT: begin
                if (req) begin
                    state_d = WAIT_IDLE;
                    idx_d   = idx;
                end
            end
            WAIT_IDLE: begin
                if (drained) begin
                    state_d    = REPORT;
                    valid_d    = 1'b1;
                    contador_d = cnt_d[idx_q];
                end
            end
            REPORT: begin
                if (req) begin
                    state_d = WAIT_IDLE;
                    idx_d   = idx;
                end else begin
                    state_d = COUNT;
                end
            end
            default: begin
                state_d = COUNT;
            end
        endcase
    end

    // FSM state and its registered report outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= COUNT;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            contador_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            contador_q <= contador_d;
        end
    end

    // Capture flags, class counters and overflow flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd0_q <= 1'b0;
            rd1_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            rd0_q <= rd0_d;
            rd1_q <= rd1_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_contador_salida.sv
// tb_contador_salida: directed stimulus with a cycle-level count model.
// FIFOs are modelled as queues; outputs are checked 1 time unit after posedge.
module tb_contador_salida;

    logic clk = 1'b0;
    logic reset_L;
    logic init;
    logic idle;
    logic D0_empty;
    logic D0_error_output;
    logic [5:0] D0_data_out;
    logic D1_empty;
    logic D1_error_output;
    logic [5:0] D1_data_out;
    logic req;
    logic [1:0] idx;
    wire D0_rd;
    wire D1_rd;
    wire valid;
    wire [4:0] contador;
    wire [3:0] overflow;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    int checks = 0;
    int errors = 0;

    int m_cnt[4];
    logic [3:0] m_ovf = 4'b0;
    int m_mode = 0;
    logic [1:0] m_idx = 2'b0;
    bit m_pend0 = 0;
    bit m_pend1 = 0;
    bit m_valid = 0;
    int m_cont = 0;
    bit pop0 = 0;
    bit pop1 = 0;
    int lat;

    contador_salida #(.BW(6), .CW(5)) dut (
        .clk(clk),
        .reset_L(reset_L),
        .init(init),
        .idle(idle),
        .D0_empty(D0_empty),
        .D0_error_output(D0_error_output),
        .D0_data_out(D0_data_out),
        .D1_empty(D1_empty),
        .D1_error_output(D1_error_output),
        .D1_data_out(D1_data_out),
        .req(req),
        .idx(idx),
        .D0_rd(D0_rd),
        .D1_rd(D1_rd),
        .valid(valid),
        .contador(contador),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // One word of class c arrives: saturating count with sticky flag.
    task automatic m_add(input int c);
        m_cnt[c] = m_cnt[c] + 1;
        if (m_cnt[c] > 31) begin
            m_cnt[c] = 31;
            m_ovf[c] = 1'b1;
        end
    endtask

    // Model step, per-cycle compare, and FIFO queue behaviour.
    always @(posedge clk) begin
        if (!reset_L) begin
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
            m_ovf = 4'b0;
            m_mode = 0;
            m_idx = 2'b0;
            m_pend0 = 0;
            m_pend1 = 0;
            m_valid = 0;
            m_cont = 0;
            pop0 = 0;
            pop1 = 0;
        end else begin
            pop0 = !D0_empty && !D0_error_output && m_mode == 0;
            pop1 = !D1_empty && !D1_error_output && m_mode == 0;
            if (init) begin
                for (int c = 0; c < 4; c++) m_cnt[c] = 0;
                m_ovf = 4'b0;
            end else begin
                if (m_pend0) m_add(int'(D0_data_out[5:4]));
                if (m_pend1) m_add(int'(D1_data_out[5:4]));
            end
            m_valid = 0;
            if (m_mode == 0) begin
                if (req) begin
                    m_mode = 1;
                    m_idx = idx;
                end
            end else if (m_mode == 1) begin
                if (idle && !m_pend0 && !m_pend1) begin
                    m_mode = 2;
                    m_valid = 1;
                    m_cont = m_cnt[m_idx];
                end
            end else begin
                if (req) begin
                    m_mode = 1;
                    m_idx = idx;
                end else begin
                    m_mode = 0;
                end
            end
            m_pend0 = pop0;
            m_pend1 = pop1;
        end
        #1;
        chk("valid", int'(valid), int'(m_valid));
        chk("contador", int'(contador), m_cont);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("D0_rd", int'(D0_rd),
            int'(reset_L && !D0_empty && !D0_error_output && m_mode == 0));
        chk("D1_rd", int'(D1_rd),
            int'(reset_L && !D1_empty && !D1_error_output && m_mode == 0));
        if (pop0) D0_data_out = q0.pop_front();
        else D0_data_out = 6'($urandom);
        if (pop1) D1_data_out = q1.pop_front();
        else D1_data_out = 6'($urandom);
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    end

    task automatic push(input int f, input logic [5:0] w);
        if (f == 0) begin
            q0.push_back(w);
            D0_empty = 1'b0;
        end else begin
            q1.push_back(w);
            D1_empty = 1'b0;
        end
    endtask

    task automatic wait_valid(output bit got, output int n);
        got = 0;
        n = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = valid;
        end
    endtask

    task automatic do_report(input logic [1:0] i, input int exp,
                             input string nm, output int l);
        bit got;
        int n;
        req = 1'b1;
        idx = i;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        got = valid;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = valid;
        end
        chk({nm, "_valid"}, int'(got), 1);
        chk(nm, int'(contador), exp);
        l = n;
        @(negedge clk);
    endtask

    initial begin
        bit got;
        int n;
        reset_L = 1'b0;
        init = 1'b0;
        idle = 1'b1;
        D0_empty = 1'b1;
        D1_empty = 1'b1;
        D0_error_output = 1'b0;
        D1_error_output = 1'b0;
        D0_data_out = '0;
        D1_data_out = '0;
        req = 1'b0;
        idx = 2'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_contador", int'(contador), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_D0_rd", int'(D0_rd), 0);
        chk("rst_D1_rd", int'(D1_rd), 0);
        reset_L = 1'b1;
        repeat (4) @(negedge clk);
        chk("empty_D0_rd", int'(D0_rd), 0);
        chk("empty_D1_rd", int'(D1_rd), 0);

        // Single stream on D0
        push(0, 6'b100001);
        push(0, 6'b101100);
        push(0, 6'b110101);
        repeat (6) @(negedge clk);
        do_report(2'b10, 2, "single_c2", lat);
        chk("latency", lat, 2);
        do_report(2'b11, 1, "single_c3", lat);

        // Same class on both FIFOs, then saturation
        for (int k = 0; k < 14; k++) begin
            push(0, {2'b00, 4'(k)});
            push(1, {2'b00, 4'(k)});
        end
        repeat (18) @(negedge clk);
        do_report(2'b00, 28, "pair_28", lat);
        for (int k = 0; k < 28; k++) begin
            push(0, {2'b00, 4'(k)});
            push(1, {2'b00, 4'(k)});
        end
        repeat (32) @(negedge clk);
        do_report(2'b00, 31, "sat_31", lat);
        chk("sat_ovf", int'(overflow), 1);

        // Error gating on D1
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        D1_error_output = 1'b1;
        for (int k = 0; k < 3; k++) push(1, {2'b01, 4'(k)});
        for (int k = 0; k < 2; k++) push(0, {2'b01, 4'(k + 8)});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("err_D1_rd", int'(D1_rd), 0);
        end
        do_report(2'b01, 2, "err_c1", lat);
        D1_error_output = 1'b0;
        repeat (8) @(negedge clk);
        do_report(2'b01, 5, "err_release", lat);

        // init wins over a same-cycle capture
        push(0, 6'b010011);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        do_report(2'b01, 0, "init_prec", lat);
        chk("init_ovf", int'(overflow), 0);

        // Request during traffic with idle low
        idle = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push(0, {2'b11, 4'(k)});
            push(1, {2'b11, 4'(k)});
        end
        @(negedge clk);
        req = 1'b1;
        idx = 2'b11;
        @(negedge clk);
        req = 1'b0;
        chk("stop_D0_rd", int'(D0_rd), 0);
        chk("stop_D1_rd", int'(D1_rd), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("busy_valid", int'(valid), 0);
        end
        idle = 1'b1;
        wait_valid(got, n);
        chk("busy_got", int'(got), 1);
        chk("busy_cnt", int'(contador), 4);
        @(negedge clk);
        repeat (14) @(negedge clk);
        do_report(2'b11, 20, "resume_c3", lat);

        // Back-to-back reports with idx re-sampled
        req = 1'b1;
        idx = 2'b10;
        wait_valid(got, n);
        chk("b2b_a_got", int'(got), 1);
        chk("b2b_a", int'(contador), 0);
        idx = 2'b11;
        @(negedge clk);
        chk("b2b_gap", int'(valid), 0);
        wait_valid(got, n);
        chk("b2b_b_got", int'(got), 1);
        chk("b2b_b", int'(contador), 20);
        req = 1'b0;
        @(negedge clk);

        // Reset during a report
        req = 1'b1;
        idx = 2'b11;
        wait_valid(got, n);
        req = 1'b0;
        chk("mid_got", int'(got), 1);
        chk("mid_cnt", int'(contador), 20);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_cnt", int'(contador), 0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        do_report(2'b11, 0, "post_rst", lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
